xalu_ise_ctrl: RTL and testbench

- Issue/response controller directly upstream of the rv32 ISE datapath (xalu_ise).
- Accepts one custom-opcode instruction plus two source operands from the core over a valid/ready handshake.
- Decodes the instruction into ise_fn/ise_imm, holds operands stable while the datapath computes, and captures the result.
- Returns the result, destination register index and an illegal flag to the core writeback over a second valid/ready handshake; one operation outstanding at a time.

---
 rtl/xalu_ise_ctrl_pkg.sv | 40 ++++
 rtl/xalu_ise_dec.sv | 27 ++
 rtl/xalu_ise_ctrl.sv | 150 +++++++++++++++
 tb/tb_xalu_ise_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/xalu_ise_ctrl_pkg.sv
// rtl/xalu_ise_ctrl_pkg.sv - shared opcode, index and state definitions for the ISE issue controller
package xalu_ise_ctrl_pkg;

    localparam logic [6:0] CUSTOM_0 = 7'b0001011;
    localparam logic [6:0] CUSTOM_1 = 7'b0101011;
    localparam logic [6:0] CUSTOM_2 = 7'b1011011;
    localparam logic [6:0] CUSTOM_3 = 7'b1111011;

    localparam logic [1:0] IDX_CUSTOM_0 = 2'd0;
    localparam logic [1:0] IDX_CUSTOM_1 = 2'd1;
    localparam logic [1:0] IDX_CUSTOM_2 = 2'd2;
    localparam logic [1:0] IDX_CUSTOM_3 = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic       is_custom;
        logic [1:0] idx;
    } op_class_t;

    // Non-custom opcodes report index 0 so ise_fn stays deterministic.
    function automatic op_class_t decode_opcode(input logic [6:0] opcode);
        op_class_t r;
        r.is_custom = 1'b1;
        r.idx       = IDX_CUSTOM_0;
        case (opcode)
            CUSTOM_0: r.idx = IDX_CUSTOM_0;
            CUSTOM_1: r.idx = IDX_CUSTOM_1;
            CUSTOM_2: r.idx = IDX_CUSTOM_2;
            CUSTOM_3: r.idx = IDX_CUSTOM_3;
            default:  r.is_custom = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/xalu_ise_dec.sv
// rtl/xalu_ise_dec.sv - combinational custom-instruction field decoder
module xalu_ise_dec
    import xalu_ise_ctrl_pkg::*;
(
    input  logic [31:0] insn,
    output logic        is_custom,
    output logic [4:0]  fn,
    output logic [6:0]  imm,
    output logic [4:0]  rd
);

    op_class_t op;
    logic      unused_insn_bits;

    always_comb begin
        op = decode_opcode(insn[6:0]);
    end

    assign is_custom = op.is_custom;
    assign fn        = {insn[14:12], op.idx};
    assign imm       = insn[31:25];
    assign rd        = insn[11:7];

    // rs1/rs2 index fields travel as operand values, not through the decoder.
    assign unused_insn_bits = ^insn[24:15];

endmodule

// File: rtl/xalu_ise_ctrl.sv
// rtl/xalu_ise_ctrl.sv - single-outstanding issue/response controller in front of the ISE datapath
module xalu_ise_ctrl
    import xalu_ise_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 8,
    parameter int ZERO_X0  = 1
) (
    input  logic        ise_clk,
    input  logic        ise_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic        flush,
    output logic        ise_val,
    output logic [4:0]  ise_fn,
    output logic [6:0]  ise_imm,
    output logic [31:0] ise_in1,
    output logic [31:0] ise_in2,
    input  logic        ise_oval,
    input  logic [31:0] ise_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        rsp_illegal,
    output logic        busy
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt;
    logic [4:0]  fn_q;
    logic [6:0]  imm_q;
    logic [4:0]  rd_q;
    logic [31:0] rs1_q, rs2_q;
    logic [31:0] rsp_data_q;
    logic        rsp_illegal_q;

    logic        dec_is_custom;
    logic [4:0]  dec_fn;
    logic [6:0]  dec_imm;
    logic [4:0]  dec_rd;

    logic        accept;
    logic        exec_hit;
    logic        exec_timeout;

    // Decoded fields are registered at accept so they stay stable through EXEC and RESP.
    xalu_ise_dec u_dec (
        .insn      (req_insn),
        .is_custom (dec_is_custom),
        .fn        (dec_fn),
        .imm       (dec_imm),
        .rd        (dec_rd)
    );

    always_ff @(posedge ise_clk or negedge ise_rst) begin
        if (!ise_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_ready    = 1'b0;
        ise_val      = 1'b0;
        rsp_valid    = 1'b0;
        accept       = 1'b0;
        exec_hit     = 1'b0;
        exec_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = ~flush;
                accept    = req_valid & ~flush;
                if (accept) begin
                    state_d = dec_is_custom ? EXEC : RESP;
                end
            end
            EXEC: begin
                ise_val = 1'b1;
                if (ise_oval) begin
                    exec_hit = 1'b1;
                    state_d  = RESP;
                end else if (wait_cnt == WAIT_LAST) begin
                    exec_timeout = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge ise_clk or negedge ise_rst) begin
        if (!ise_rst) begin
            wait_cnt      <= 8'd0;
            fn_q          <= 5'd0;
            imm_q         <= 7'd0;
            rd_q          <= 5'd0;
            rs1_q         <= 32'd0;
            rs2_q         <= 32'd0;
            rsp_data_q    <= 32'd0;
            rsp_illegal_q <= 1'b0;
        end else if (accept) begin
            wait_cnt      <= 8'd0;
            fn_q          <= dec_fn;
            imm_q         <= dec_imm;
            rd_q          <= dec_rd;
            rs1_q         <= req_rs1;
            rs2_q         <= req_rs2;
            rsp_data_q    <= 32'd0;
            rsp_illegal_q <= ~dec_is_custom;
        end else if (!flush) begin
            if (exec_hit) begin
                rsp_data_q    <= ise_out;
                rsp_illegal_q <= 1'b0;
            end else if (exec_timeout) begin
                rsp_data_q    <= 32'd0;
                rsp_illegal_q <= 1'b1;
            end else if (state_q == EXEC) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    assign ise_fn      = fn_q;
    assign ise_imm     = imm_q;
    assign ise_in1     = rs1_q;
    assign ise_in2     = rs2_q;
    assign rsp_rd      = rd_q;
    assign rsp_illegal = rsp_illegal_q;
    assign busy        = (state_q != IDLE);

    // Writes to x0 must never leak a value back to the core.
    assign rsp_data = ((ZERO_X0 != 0) && (rd_q == 5'd0)) ? 32'd0 : rsp_data_q;

endmodule

// File: tb/tb_xalu_ise_ctrl.sv
// tb/tb_xalu_ise_ctrl.sv - directed self-checking bench for xalu_ise_ctrl
module tb_xalu_ise_ctrl;

    logic        ise_clk = 1'b0;
    logic        ise_rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_insn = 32'd0;
    logic [31:0] req_rs1 = 32'd0;
    logic [31:0] req_rs2 = 32'd0;
    logic        flush = 1'b0;
    logic        ise_val;
    logic [4:0]  ise_fn;
    logic [6:0]  ise_imm;
    logic [31:0] ise_in1;
    logic [31:0] ise_in2;
    logic        ise_oval = 1'b0;
    logic [31:0] ise_out = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_illegal;
    logic        busy;

    int tests = 0;
    int fails = 0;

    xalu_ise_ctrl #(.MAX_WAIT(8), .ZERO_X0(1)) dut (
        .ise_clk     (ise_clk),
        .ise_rst     (ise_rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_insn    (req_insn),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .flush       (flush),
        .ise_val     (ise_val),
        .ise_fn      (ise_fn),
        .ise_imm     (ise_imm),
        .ise_in1     (ise_in1),
        .ise_in2     (ise_in2),
        .ise_oval    (ise_oval),
        .ise_out     (ise_out),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_rd      (rsp_rd),
        .rsp_illegal (rsp_illegal),
        .busy        (busy)
    );

    always #5 ise_clk = ~ise_clk;

    typedef struct {
        string       name;
        logic [31:0] insn;
        logic [31:0] rs1;
        logic [31:0] rs2;
        int          delay;
        logic [31:0] out;
        logic [4:0]  exp_fn;
        logic [6:0]  exp_imm;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        logic        exp_illegal;
        int          exp_exec;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2, input string name);
        @(negedge ise_clk);
        req_valid = 1'b1;
        req_insn  = insn;
        req_rs1   = rs1;
        req_rs2   = rs2;
        check({name, ".req_ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge ise_clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int  cycles;
        logic stable;
        cycles = 0;
        stable = 1'b1;
        issue(v.insn, v.rs1, v.rs2, v.name);
        while (ise_val === 1'b1 && cycles < 20) begin
            if (cycles == 0) begin
                check({v.name, ".ise_fn"},  {27'd0, ise_fn},  {27'd0, v.exp_fn});
                check({v.name, ".ise_imm"}, {25'd0, ise_imm}, {25'd0, v.exp_imm});
            end
            if (ise_in1 !== v.rs1 || ise_in2 !== v.rs2) stable = 1'b0;
            ise_oval = (cycles == v.delay);
            ise_out  = v.out;
            cycles++;
            @(posedge ise_clk);
            #1;
        end
        ise_oval = 1'b0;
        check({v.name, ".operands_stable"}, {31'd0, stable}, 32'd1);
        check({v.name, ".exec_cycles"}, cycles, v.exp_exec);
        check({v.name, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({v.name, ".rsp_data"}, rsp_data, v.exp_data);
        check({v.name, ".rsp_rd"}, {27'd0, rsp_rd}, {27'd0, v.exp_rd});
        check({v.name, ".rsp_illegal"}, {31'd0, rsp_illegal}, {31'd0, v.exp_illegal});
        rsp_ready = 1'b1;
        @(posedge ise_clk);
        #1;
        rsp_ready = 1'b0;
        check({v.name, ".idle_after"}, {30'd0, busy, rsp_valid}, 32'd0);
    endtask

    initial begin
        logic ok;
        vecs[0] = '{"c1_basic", 32'h000002AB, 32'h12345678, 32'h9ABCDEF0, 0, 32'hCAFEF00D,
                    5'b00001, 7'h00, 5'd5, 32'hCAFEF00D, 1'b0, 1};
        vecs[1] = '{"c2_funct7", 32'h800001DB, 32'h0000AAAA, 32'h0000BBBB, 0, 32'h11112222,
                    5'b00010, 7'h40, 5'd3, 32'h11112222, 1'b0, 1};
        vecs[2] = '{"c0_slow", 32'h0200538B, 32'hA5A5A5A5, 32'h5A5A5A5A, 3, 32'h5A5A5A5A,
                    5'b10100, 7'h01, 5'd7, 32'h5A5A5A5A, 1'b0, 4};
        vecs[3] = '{"c3_timeout", 32'h0000757B, 32'h00000001, 32'h00000002, 255, 32'hFFFF0000,
                    5'b11111, 7'h00, 5'd10, 32'h00000000, 1'b1, 8};
        vecs[4] = '{"noncustom", 32'h00000033, 32'h00000003, 32'h00000004, 0, 32'h12121212,
                    5'b00000, 7'h00, 5'd0, 32'h00000000, 1'b1, 0};
        vecs[5] = '{"x0_dest", 32'h0000100B, 32'h00000005, 32'h00000006, 0, 32'hFFFFFFFF,
                    5'b00100, 7'h00, 5'd0, 32'h00000000, 1'b0, 1};
        vecs[6] = '{"last_wait", 32'h0000008B, 32'h00000007, 32'h00000008, 7, 32'h0BADBEEF,
                    5'b00000, 7'h00, 5'd1, 32'h0BADBEEF, 1'b0, 8};

        #12;
        check("reset.outputs", {27'd0, ise_val, rsp_valid, busy, rsp_illegal, 1'b0}, 32'd0);
        check("reset.rsp_data", rsp_data, 32'd0);
        check("reset.ise_in1", ise_in1, 32'd0);
        @(negedge ise_clk);
        ise_rst = 1'b1;
        #1;
        check("reset.req_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // Held response under backpressure; a request during RESP/handshake must not be taken.
        issue(32'h000002AB, 32'h1, 32'h2, "bp");
        ise_oval = 1'b1;
        ise_out  = 32'h13579BDF;
        @(posedge ise_clk);
        #1;
        ise_oval  = 1'b0;
        req_valid = 1'b1;
        req_insn  = 32'h00000033;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h13579BDF || rsp_rd !== 5'd5 || req_ready !== 1'b0)
                ok = 1'b0;
            ise_oval = 1'b1;
            ise_out  = 32'hDEAD0000 + 32'(i);
            @(posedge ise_clk);
            #1;
        end
        ise_oval = 1'b0;
        check("bp.held_5_cycles", {31'd0, ok}, 32'd1);
        check("bp.rsp_data", rsp_data, 32'h13579BDF);
        rsp_ready = 1'b1;
        check("bp.req_ready_at_handshake", {31'd0, req_ready}, 32'd0);
        @(posedge ise_clk);
        #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("bp.no_back_to_back", {31'd0, busy}, 32'd0);

        // Flush during EXEC discards the op.
        issue(32'h0000757B, 32'h9, 32'hA, "flush_exec");
        check("flush_exec.in_exec", {31'd0, ise_val}, 32'd1);
        @(posedge ise_clk);
        #1;
        flush = 1'b1;
        @(posedge ise_clk);
        #1;
        flush = 1'b0;
        check("flush_exec.idle", {30'd0, busy, ise_val}, 32'd0);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b0) ok = 1'b0;
            @(posedge ise_clk);
            #1;
        end
        check("flush_exec.no_rsp", {31'd0, ok}, 32'd1);

        // Flush with a request in IDLE blocks acceptance.
        @(negedge ise_clk);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_insn  = 32'h000002AB;
        #1;
        check("flush_idle.req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge ise_clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        check("flush_idle.not_accepted", {31'd0, busy}, 32'd0);

        // Asynchronous reset in RESP.
        issue(32'h000002AB, 32'h55, 32'h66, "rst_resp");
        ise_oval = 1'b1;
        ise_out  = 32'hDEADBEEF;
        @(posedge ise_clk);
        #1;
        ise_oval = 1'b0;
        check("rst_resp.in_resp", {31'd0, rsp_valid}, 32'd1);
        @(negedge ise_clk);
        ise_rst = 1'b0;
        #1;
        check("rst_resp.ctrl", {27'd0, ise_val, rsp_valid, busy, rsp_illegal, 1'b0}, 32'd0);
        check("rst_resp.rsp_data", rsp_data, 32'd0);
        check("rst_resp.fields", {ise_fn, ise_imm, rsp_rd}, 17'd0);
        check("rst_resp.ise_in2", ise_in2, 32'd0);
        @(negedge ise_clk);
        ise_rst = 1'b1;
        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
